// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller: state encoding,
// opcode constants, ALU-op codes, datapath mux-select codes, and the
// state-to-control-word decode used by multicycle_ctrl_fsm.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } ctrlStateT;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Per-state control word; fetchStrobe marks the state whose irWrite and
  // PC update are qualified by memReady at the top level.
  typedef struct packed {
    logic       adrSrc;
    logic       fetchStrobe;
    logic       memWrite;
    logic       regWrite;
    logic       branch;
    logic       pcUpdate;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrlWordT;

  // Unlisted selects and strobes stay 0, so TRAP and spare codes decode to all-zero.
  function automatic ctrlWordT decodeState(input ctrlStateT s);
    ctrlWordT w;
    w = '0;
    case (s)
      FETCH: begin
        w.fetchStrobe = 1'b1;
        w.aluSrcA     = SRCA_PC;
        w.aluSrcB     = SRCB_FOUR;
        w.aluOp       = ALUOP_ADD;
        w.resultSrc   = RES_ALURESULT;
      end
      DECODE: begin
        w.aluSrcA = SRCA_OLDPC;
        w.aluSrcB = SRCB_IMM;
        w.aluOp   = ALUOP_ADD;
      end
      MEMADR: begin
        w.aluSrcA = SRCA_RS1;
        w.aluSrcB = SRCB_IMM;
        w.aluOp   = ALUOP_ADD;
      end
      MEMREAD: begin
        w.adrSrc    = 1'b1;
        w.resultSrc = RES_ALUOUT;
      end
      MEMWB: begin
        w.resultSrc = RES_DATA;
        w.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        w.adrSrc    = 1'b1;
        w.resultSrc = RES_ALUOUT;
        w.memWrite  = 1'b1;
      end
      EXECUTER: begin
        w.aluSrcA = SRCA_RS1;
        w.aluSrcB = SRCB_RS2;
        w.aluOp   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        w.aluSrcA = SRCA_RS1;
        w.aluSrcB = SRCB_IMM;
        w.aluOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        w.resultSrc = RES_ALUOUT;
        w.regWrite  = 1'b1;
      end
      BEQ: begin
        w.aluSrcA   = SRCA_RS1;
        w.aluSrcB   = SRCB_RS2;
        w.aluOp     = ALUOP_SUB;
        w.resultSrc = RES_ALUOUT;
        w.branch    = 1'b1;
      end
      JAL: begin
        w.aluSrcA   = SRCA_OLDPC;
        w.aluSrcB   = SRCB_FOUR;
        w.aluOp     = ALUOP_ADD;
        w.resultSrc = RES_ALUOUT;
        w.pcUpdate  = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles and raises a sticky memTimeout flag
// once the count reaches MEM_TIMEOUT. MEM_TIMEOUT = 0 disables the timer.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic memTimeout
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

  logic [TMR_W-1:0] waitCount;
  logic [TMR_W-1:0] countNext;

  // Next count: increment while waiting, saturate at the limit, clear otherwise.
  always_comb begin
    countNext = '0;
    if (waiting) begin
      countNext = (waitCount == LIMIT) ? waitCount : waitCount + 1'b1;
    end
  end

  // Counter and sticky flag; the flag rises on the same edge the count reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCount  <= '0;
      memTimeout <= 1'b0;
    end else begin
      waitCount <= countNext;
      if ((MEM_TIMEOUT != 0) && waiting && (countNext == LIMIT)) begin
        memTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller of the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Moore FSM with a registered control word; memReady qualifies the fetch
// strobes and zero qualifies the branch PC write. Reset forces all outputs 0.
// Optional macro ILLEGAL_TRAP_EN: unlisted opcodes park the FSM in TRAP and
// drive illegalInstr; without it they fall through to FETCH as a NOP.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       memTimeout
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegalInstr
`endif
);

  ctrlStateT state;
  ctrlStateT nextState;
  ctrlWordT  ctrlQ;
  logic      waiting;
  logic      fetchDone;

  // Next-state selection from the current state, opcode and memory handshake.
  always_comb begin
    nextState = state;
    case (state)
      FETCH:    nextState = memReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECUTER;
          OP_I:         nextState = EXECUTEI;
          OP_BEQ:       nextState = BEQ;
          OP_JAL:       nextState = JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      nextState = TRAP;
`else
          default:      nextState = FETCH;
`endif
        endcase
      end
      MEMADR:   nextState = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  nextState = memReady ? MEMWB : MEMREAD;
      MEMWB:    nextState = FETCH;
      MEMWRITE: nextState = memReady ? FETCH : MEMWRITE;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      JAL:      nextState = ALUWB;
      TRAP:     nextState = TRAP;
      default:  nextState = FETCH;
    endcase
  end

  // State register plus the control word registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctrlQ <= decodeState(FETCH);
    end else begin
      state <= nextState;
      ctrlQ <= decodeState(nextState);
    end
  end

  assign waiting   = !memReady && ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE));
  assign fetchDone = ctrlQ.fetchStrobe && memReady;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) uWaitTimer (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .memTimeout(memTimeout)
  );

  assign pcWrite   = !reset && ((ctrlQ.branch && zero) || ctrlQ.pcUpdate || fetchDone);
  assign irWrite   = !reset && fetchDone;
  assign adrSrc    = !reset && ctrlQ.adrSrc;
  assign memWrite  = !reset && ctrlQ.memWrite;
  assign regWrite  = !reset && ctrlQ.regWrite;
  assign resultSrc = reset ? 2'b00 : ctrlQ.resultSrc;
  assign aluSrcA   = reset ? 2'b00 : ctrlQ.aluSrcA;
  assign aluSrcB   = reset ? 2'b00 : ctrlQ.aluSrcB;
  assign aluOp     = reset ? 2'b00 : ctrlQ.aluOp;

`ifdef ILLEGAL_TRAP_EN
  assign illegalInstr = !reset && (state == TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: directed scenarios followed by a random
// instruction stream, checked against a step-table reference model and a
// consecutive-wait counter. Honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_BAD = 7'b1111111;
  localparam int TIMEOUT = 4;

  typedef enum {
    sReset, sFetch, sDecode, sMemAdr, sMemRead, sMemWb, sMemWrite,
    sExecR, sExecI, sAluWb, sBeq, sJal, sTrap
  } stepT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       memReady = 1'b1;
  logic       pcWrite, adrSrc, irWrite, memWrite, regWrite, memTimeout;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
`ifdef ILLEGAL_TRAP_EN
  logic       illegalInstr;
`endif

  int  checks = 0;
  int  errors = 0;
  int  waitRun = 0;
  bit  stickyTo = 1'b0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TIMEOUT), .TMR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .memReady  (memReady),
    .pcWrite   (pcWrite),
    .adrSrc    (adrSrc),
    .irWrite   (irWrite),
    .memWrite  (memWrite),
    .regWrite  (regWrite),
    .resultSrc (resultSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .memTimeout(memTimeout)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegalInstr(illegalInstr)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expected {pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc, aluSrcA, aluSrcB, aluOp}.
  function automatic logic [12:0] expectFor(input stepT s, input bit rdy, input bit z);
    logic pw, as, ir, mw, rw;
    logic [1:0] rs, sa, sb, ao;
    {pw, as, ir, mw, rw, rs, sa, sb, ao} = '0;
    case (s)
      sFetch:    begin pw = rdy; ir = rdy; rs = 2'b10; sb = 2'b10; end
      sDecode:   begin sa = 2'b01; sb = 2'b01; end
      sMemAdr:   begin sa = 2'b10; sb = 2'b01; end
      sMemRead:  begin as = 1'b1; end
      sMemWb:    begin rs = 2'b01; rw = 1'b1; end
      sMemWrite: begin as = 1'b1; mw = 1'b1; end
      sExecR:    begin sa = 2'b10; ao = 2'b10; end
      sExecI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
      sAluWb:    begin rw = 1'b1; end
      sBeq:      begin sa = 2'b10; ao = 2'b01; pw = z; end
      sJal:      begin sa = 2'b01; sb = 2'b10; pw = 1'b1; end
      default:   ;
    endcase
    return {pw, as, ir, mw, rw, rs, sa, sb, ao};
  endfunction

  task automatic checkOutput(input string tag, input logic [12:0] observed, input logic [12:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check, then advance the wait model.
  task automatic applyStimulus(input stepT s, input bit rdy, input bit z, input logic [6:0] opv);
    @(negedge clk);
    reset    = (s == sReset);
    memReady = rdy;
    zero     = z;
    op       = opv;
    #1;
    checkOutput({s.name(), ".ctrl"},
                {pcWrite, adrSrc, irWrite, memWrite, regWrite, resultSrc, aluSrcA, aluSrcB, aluOp},
                expectFor(s, rdy, z));
    if (s != sReset) begin
      checkOutput({s.name(), ".timeout"}, 13'(memTimeout), 13'(stickyTo));
    end
`ifdef ILLEGAL_TRAP_EN
    checkOutput({s.name(), ".illegal"}, 13'(illegalInstr), 13'(s == sTrap));
`endif
    if (s == sReset) begin
      waitRun  = 0;
      stickyTo = 1'b0;
    end else if (!rdy && (s == sFetch || s == sMemRead || s == sMemWrite)) begin
      waitRun++;
      if (waitRun >= TIMEOUT) stickyTo = 1'b1;
    end else begin
      waitRun = 0;
    end
  endtask

  // One whole instruction from fetch to its final step.
  task automatic runInstr(input logic [6:0] opv, input int fetchWaits, input int memWaits, input bit zeroVal);
    repeat (fetchWaits) applyStimulus(sFetch, 1'b0, rbit(), opv);
    applyStimulus(sFetch, 1'b1, rbit(), opv);
    applyStimulus(sDecode, rbit(), rbit(), opv);
    case (opv)
      OPC_LW: begin
        applyStimulus(sMemAdr, rbit(), rbit(), opv);
        repeat (memWaits) applyStimulus(sMemRead, 1'b0, rbit(), opv);
        applyStimulus(sMemRead, 1'b1, rbit(), opv);
        applyStimulus(sMemWb, rbit(), rbit(), opv);
      end
      OPC_SW: begin
        applyStimulus(sMemAdr, rbit(), rbit(), opv);
        repeat (memWaits) applyStimulus(sMemWrite, 1'b0, rbit(), opv);
        applyStimulus(sMemWrite, 1'b1, rbit(), opv);
      end
      OPC_R: begin
        applyStimulus(sExecR, rbit(), rbit(), opv);
        applyStimulus(sAluWb, rbit(), rbit(), opv);
      end
      OPC_I: begin
        applyStimulus(sExecI, rbit(), rbit(), opv);
        applyStimulus(sAluWb, rbit(), rbit(), opv);
      end
      OPC_BEQ: applyStimulus(sBeq, rbit(), zeroVal, opv);
      OPC_JAL: begin
        applyStimulus(sJal, rbit(), rbit(), opv);
        applyStimulus(sAluWb, rbit(), rbit(), opv);
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [6:0] opList [7];
    int nOps;
    opList = '{OPC_LW, OPC_SW, OPC_R, OPC_I, OPC_BEQ, OPC_JAL, OPC_BAD};
`ifdef ILLEGAL_TRAP_EN
    nOps = 6;
`else
    nOps = 7;
`endif

    $display("[TB] reset and basic instructions");
    repeat (3) applyStimulus(sReset, 1'b1, 1'b0, 7'd0);
    runInstr(OPC_LW, 0, 0, 1'b0);
    runInstr(OPC_SW, 0, 4, 1'b0);
    runInstr(OPC_BEQ, 0, 0, 1'b1);
    runInstr(OPC_BEQ, 0, 0, 1'b0);
    runInstr(OPC_JAL, 1, 0, 1'b0);
    runInstr(OPC_R, 0, 0, 1'b0);
    runInstr(OPC_I, 2, 0, 1'b0);

    $display("[TB] reset during a store wait");
    applyStimulus(sFetch, 1'b1, 1'b0, OPC_SW);
    applyStimulus(sDecode, 1'b0, 1'b0, OPC_SW);
    applyStimulus(sMemAdr, 1'b0, 1'b0, OPC_SW);
    applyStimulus(sMemWrite, 1'b0, 1'b0, OPC_SW);
    applyStimulus(sMemWrite, 1'b0, 1'b0, OPC_SW);
    applyStimulus(sReset, 1'b0, 1'b0, OPC_SW);
    runInstr(OPC_LW, 0, 1, 1'b0);

    $display("[TB] memory wait timeout");
    applyStimulus(sReset, 1'b1, 1'b0, 7'd0);
    runInstr(OPC_R, 6, 0, 1'b0);
    runInstr(OPC_LW, 0, 2, 1'b0);
    applyStimulus(sReset, 1'b1, 1'b0, 7'd0);
    runInstr(OPC_I, 3, 0, 1'b0);

    $display("[TB] random instruction stream");
    for (int i = 0; i < 60; i++) begin
      int fw, mwt;
      if (i % 12 == 11) applyStimulus(sReset, rbit(), rbit(), 7'd0);
      fw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
      mwt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : 0;
      runInstr(opList[$urandom_range(0, nOps - 1)], fw, mwt, rbit());
    end

    $display("[TB] unlisted opcode");
    applyStimulus(sReset, 1'b1, 1'b0, 7'd0);
    applyStimulus(sFetch, 1'b1, 1'b0, OPC_BAD);
    applyStimulus(sDecode, 1'b1, 1'b0, OPC_BAD);
`ifdef ILLEGAL_TRAP_EN
    repeat (20) applyStimulus(sTrap, rbit(), rbit(), OPC_BAD);
    applyStimulus(sReset, 1'b1, 1'b0, 7'd0);
`endif
    runInstr(OPC_R, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
